// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic pipeline-stage register with optional skid entry
// Carries a control bundle (zeroed on bubble/flush) and a data bundle (held) between two stages.
module pipe_stage_elastic #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter bit          SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  if (SKID) begin : g_skid
    state_e              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic                push;
    logic                pop;

    assign push = in_valid & in_ready_q;
    assign pop  = (state_q != ST_EMPTY) & out_ready;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q     <= ST_EMPTY;
        in_ready_q  <= 1'b1;
        main_ctrl_q <= '0;
        main_data_q <= '0;
        skid_ctrl_q <= '0;
        skid_data_q <= '0;
      end else begin
        state_q     <= state_d;
        in_ready_q  <= in_ready_d;
        main_ctrl_q <= main_ctrl_d;
        main_data_q <= main_data_d;
        skid_ctrl_q <= skid_ctrl_d;
        skid_data_q <= skid_data_d;
      end
    end

    always_comb begin
      state_d = state_q;
      if (flush) begin
        state_d = ST_EMPTY;
      end else begin
        case (state_q)
          ST_EMPTY: if (push) state_d = ST_ONE;
          ST_ONE: begin
            if (push && !pop) state_d = ST_FULL;
            else if (!push && pop) state_d = ST_EMPTY;
          end
          ST_FULL:  if (pop) state_d = ST_ONE;
          default:  state_d = ST_EMPTY;
        endcase
      end
      // Registered ready: derived from where the stage will be, not where it is.
      in_ready_d = (state_d != ST_FULL);
    end

    always_comb begin
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      if (flush) begin
        main_ctrl_d = '0;
        skid_ctrl_d = '0;
        skid_data_d = '0;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (push) begin
              main_ctrl_d = in_ctrl;
              main_data_d = in_data;
            end
          end
          ST_ONE: begin
            if (push && pop) begin
              main_ctrl_d = in_ctrl;
              main_data_d = in_data;
            end else if (push) begin
              skid_ctrl_d = in_ctrl;
              skid_data_d = in_data;
            end else if (pop) begin
              main_ctrl_d = '0;
            end
          end
          ST_FULL: begin
            if (pop) begin
              main_ctrl_d = skid_ctrl_q;
              main_data_d = skid_data_q;
              skid_ctrl_d = '0;
              skid_data_d = '0;
            end
          end
          default: begin
            main_ctrl_d = '0;
          end
        endcase
      end
    end

    always_comb begin
      in_ready  = in_ready_q;
      out_valid = (state_q != ST_EMPTY);
      out_ctrl  = main_ctrl_q;
      out_data  = main_data_q;
      case (state_q)
        ST_ONE:  occupancy = 2'd1;
        ST_FULL: occupancy = 2'd2;
        default: occupancy = 2'd0;
      endcase
    end
  end else begin : g_single
    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ready_c;
    logic              push;
    logic              pop;

    assign ready_c = !valid_q | out_ready;
    assign push    = in_valid & ready_c;
    assign pop     = valid_q & out_ready;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        ctrl_q  <= '0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        ctrl_q  <= ctrl_d;
        data_q  <= data_d;
      end
    end

    always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      if (flush) begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end else if (push) begin
        valid_d = 1'b1;
        ctrl_d  = in_ctrl;
        data_d  = in_data;
      end else if (pop) begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end
    end

    always_comb begin
      in_ready  = ready_c;
      out_valid = valid_q;
      out_ctrl  = ctrl_q;
      out_data  = data_q;
      occupancy = {1'b0, valid_q};
    end
  end

endmodule
